// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_unit
//  Description : Pipeline hazard control for the execute stage. Tracks the
//                destination tags of in-flight instructions in EX/MEM/WB,
//                drives operand-forwarding selects and the load-use stall,
//                and turns a taken branch into a multi-cycle flush.
//                Optional build macro HAZARD_R0_ZERO_EN: when defined,
//                register 0 is hardwired zero and never forwards or stalls.
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_unit #(
    parameter int REG_ADDR_W   = 3,
    parameter int FLUSH_CYCLES = 2      // legal range 1..7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_regwrite,
    input  logic                  id_memread,
    input  logic                  branch_taken,
    output logic [1:0]            forwardA,
    output logic [1:0]            forwardB,
    output logic                  stall,
    output logic                  flush,
    output logic [7:0]            stall_count,
    output logic [7:0]            flush_count
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    localparam logic [2:0] c_CNT_LOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [7:0] c_CNT_MAX  = 8'hFF;

    // EX slot keeps every decode field; MEM and WB only need what forwarding
    // inspects (valid, rd, regwrite), so the source fields stop at EX.
    logic                  r_ex_valid;
    logic [REG_ADDR_W-1:0] r_ex_rs1;
    logic [REG_ADDR_W-1:0] r_ex_rs2;
    logic                  r_ex_use1;
    logic                  r_ex_use2;
    logic [REG_ADDR_W-1:0] r_ex_rd;
    logic                  r_ex_regwrite;
    logic                  r_ex_memread;
    logic                  r_mem_valid;
    logic [REG_ADDR_W-1:0] r_mem_rd;
    logic                  r_mem_regwrite;
    logic                  r_wb_valid;
    logic [REG_ADDR_W-1:0] r_wb_rd;
    logic                  r_wb_regwrite;

    state_t     r_state;
    state_t     w_state_next;
    logic [2:0] r_flush_cnt;
    logic [2:0] w_flush_cnt_next;
    logic [7:0] r_stall_count;
    logic [7:0] r_flush_count;

    logic w_mem_wr;         // MEM slot is a live register producer
    logic w_wb_wr;          // WB slot is a live register producer
    logic w_ex_load;        // EX slot is a live load that can cause a stall
    logic w_ex_load_en;     // decode instruction advances into EX
    logic w_branch_accept;  // taken branch seen while running

`ifdef HAZARD_R0_ZERO_EN
    // r0 always reads as zero, so a producer targeting it is never a hazard.
    assign w_mem_wr  = r_mem_valid && r_mem_regwrite && (r_mem_rd != '0);
    assign w_wb_wr   = r_wb_valid  && r_wb_regwrite  && (r_wb_rd  != '0);
    assign w_ex_load = r_ex_valid  && r_ex_memread   && (r_ex_rd  != '0);
`else
    assign w_mem_wr  = r_mem_valid && r_mem_regwrite;
    assign w_wb_wr   = r_wb_valid  && r_wb_regwrite;
    assign w_ex_load = r_ex_valid  && r_ex_memread;
`endif

    assign flush           = (r_state == ST_FLUSH);
    assign stall           = (r_state == ST_RUN) && id_valid && w_ex_load &&
                             ((id_uses_rs1 && (id_rs1 == r_ex_rd)) ||
                              (id_uses_rs2 && (id_rs2 == r_ex_rd)));
    assign w_ex_load_en    = id_valid && !stall && !flush;
    assign w_branch_accept = (r_state == ST_RUN) && branch_taken;
    assign stall_count     = r_stall_count;
    assign flush_count     = r_flush_count;

    // Forward selects: youngest producer (MEM) wins over WB.
    always_comb begin
        forwardA = 2'b00;
        forwardB = 2'b00;
        if (r_ex_use1 && w_mem_wr && (r_mem_rd == r_ex_rs1))
            forwardA = 2'b10;
        else if (r_ex_use1 && w_wb_wr && (r_wb_rd == r_ex_rs1))
            forwardA = 2'b01;
        if (r_ex_use2 && w_mem_wr && (r_mem_rd == r_ex_rs2))
            forwardB = 2'b10;
        else if (r_ex_use2 && w_wb_wr && (r_wb_rd == r_ex_rs2))
            forwardB = 2'b01;
    end

    // Tag pipeline: shift EX->MEM->WB, load EX from decode or with a bubble.
    // A bubble clears every EX field so it can never request forwarding.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex_valid     <= 1'b0;
            r_ex_rs1       <= '0;
            r_ex_rs2       <= '0;
            r_ex_use1      <= 1'b0;
            r_ex_use2      <= 1'b0;
            r_ex_rd        <= '0;
            r_ex_regwrite  <= 1'b0;
            r_ex_memread   <= 1'b0;
            r_mem_valid    <= 1'b0;
            r_mem_rd       <= '0;
            r_mem_regwrite <= 1'b0;
            r_wb_valid     <= 1'b0;
            r_wb_rd        <= '0;
            r_wb_regwrite  <= 1'b0;
        end else begin
            r_wb_valid     <= r_mem_valid;
            r_wb_rd        <= r_mem_rd;
            r_wb_regwrite  <= r_mem_regwrite;
            r_mem_valid    <= r_ex_valid;
            r_mem_rd       <= r_ex_rd;
            r_mem_regwrite <= r_ex_regwrite;
            if (w_ex_load_en) begin
                r_ex_valid    <= 1'b1;
                r_ex_rs1      <= id_rs1;
                r_ex_rs2      <= id_rs2;
                r_ex_use1     <= id_uses_rs1;
                r_ex_use2     <= id_uses_rs2;
                r_ex_rd       <= id_rd;
                r_ex_regwrite <= id_regwrite;
                r_ex_memread  <= id_memread;
            end else begin
                r_ex_valid    <= 1'b0;
                r_ex_rs1      <= '0;
                r_ex_rs2      <= '0;
                r_ex_use1     <= 1'b0;
                r_ex_use2     <= 1'b0;
                r_ex_rd       <= '0;
                r_ex_regwrite <= 1'b0;
                r_ex_memread  <= 1'b0;
            end
        end
    end

    // Branch FSM state and flush-length counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_RUN;
            r_flush_cnt <= 3'd0;
        end else begin
            r_state     <= w_state_next;
            r_flush_cnt <= w_flush_cnt_next;
        end
    end

    // Branch FSM next state; branch_taken is ignored while flushing because
    // it originates from an instruction being squashed.
    always_comb begin
        w_state_next     = r_state;
        w_flush_cnt_next = r_flush_cnt;
        case (r_state)
            ST_RUN: begin
                if (branch_taken) begin
                    w_state_next     = ST_FLUSH;
                    w_flush_cnt_next = c_CNT_LOAD;
                end
            end
            ST_FLUSH: begin
                if (r_flush_cnt == 3'd0)
                    w_state_next = ST_RUN;
                else
                    w_flush_cnt_next = r_flush_cnt - 3'd1;
            end
            default: begin
                w_state_next     = ST_RUN;
                w_flush_cnt_next = 3'd0;
            end
        endcase
    end

    // Saturating event counters for stalls and accepted branches.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_count <= 8'd0;
            r_flush_count <= 8'd0;
        end else begin
            if (stall && (r_stall_count != c_CNT_MAX))
                r_stall_count <= r_stall_count + 8'd1;
            if (w_branch_accept && (r_flush_count != c_CNT_MAX))
                r_flush_count <= r_flush_count + 8'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_unit
//  Description : Self-checking bench for hazard_unit. Directed scenarios
//                followed by randomized traffic, all compared against an
//                instruction-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hazard_unit;

    localparam int RW = 3;
    localparam int FC = 2;
`ifdef HAZARD_R0_ZERO_EN
    localparam bit R0Z = 1'b1;
`else
    localparam bit R0Z = 1'b0;
`endif

    typedef struct packed {
        logic          v;
        logic [RW-1:0] rs1;
        logic [RW-1:0] rs2;
        logic          u1;
        logic          u2;
        logic [RW-1:0] rd;
        logic          rw;
        logic          mr;
    } inst_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          id_valid, id_uses_rs1, id_uses_rs2, id_regwrite, id_memread;
    logic [RW-1:0] id_rs1, id_rs2, id_rd;
    logic          branch_taken;
    logic [1:0]    forwardA, forwardB;
    logic          stall, flush;
    logic [7:0]    stall_count, flush_count;

    hazard_unit #(.REG_ADDR_W(RW), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .branch_taken(branch_taken),
        .forwardA(forwardA), .forwardB(forwardB),
        .stall(stall), .flush(flush),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: the instructions currently in EX (0), MEM (1), WB (2),
    // remaining flush cycles, and event counts.
    inst_t p [3];
    int    rem;
    int    m_sc, m_fc;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic inst_t mk(input int rs1, input int rs2, input bit u1, input bit u2,
                                 input int rd, input bit rw, input bit mr);
        inst_t t;
        t.v = 1'b1; t.rs1 = RW'(rs1); t.rs2 = RW'(rs2); t.u1 = u1; t.u2 = u2;
        t.rd = RW'(rd); t.rw = rw; t.mr = mr;
        return t;
    endfunction

    function automatic bit producer(input inst_t s, input logic [RW-1:0] r);
        return s.v && s.rw && (s.rd == r) && !(R0Z && (s.rd == '0));
    endfunction

    // Nearest older instruction writing the register supplies the operand.
    function automatic logic [1:0] model_fwd(input logic [RW-1:0] src, input bit used);
        if (!used)               return 2'b00;
        if (producer(p[1], src)) return 2'b10;
        if (producer(p[2], src)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit model_stall(input inst_t d);
        bit hit;
        if (rem != 0 || !d.v || !p[0].v || !p[0].mr) return 1'b0;
        if (R0Z && p[0].rd == '0) return 1'b0;
        hit = (d.u1 && d.rs1 == p[0].rd) || (d.u2 && d.rs2 == p[0].rd);
        return hit;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 3; i++) p[i] = '0;
        rem = 0; m_sc = 0; m_fc = 0;
    endtask

    // One clock: drive inputs, compare all outputs, advance the model.
    task automatic cycle(input inst_t d, input bit bt, input bit rst);
        bit         e_stall;
        logic [1:0] e_fa, e_fb;
        @(posedge clk);
        #1;
        id_valid = d.v; id_rs1 = d.rs1; id_rs2 = d.rs2;
        id_uses_rs1 = d.u1; id_uses_rs2 = d.u2; id_rd = d.rd;
        id_regwrite = d.rw; id_memread = d.mr;
        branch_taken = bt; reset = rst;
        #1;
        e_stall = model_stall(d);
        e_fa    = model_fwd(p[0].rs1, p[0].u1);
        e_fb    = model_fwd(p[0].rs2, p[0].u2);
        check("forwardA",    {6'd0, forwardA}, {6'd0, e_fa});
        check("forwardB",    {6'd0, forwardB}, {6'd0, e_fb});
        check("stall",       {7'd0, stall},    {7'd0, e_stall});
        check("flush",       {7'd0, flush},    {7'd0, (rem != 0)});
        check("stall_count", stall_count,      8'(m_sc));
        check("flush_count", flush_count,      8'(m_fc));
        if (rst) begin
            model_clear();
        end else begin
            p[2] = p[1];
            p[1] = p[0];
            p[0] = (d.v && !e_stall && rem == 0) ? d : inst_t'('0);
            if (e_stall && m_sc < 255) m_sc++;
            if (rem > 0) rem--;
            else if (bt) begin
                rem = FC;
                if (m_fc < 255) m_fc++;
            end
        end
    endtask

    function automatic inst_t rnd_inst(input int lo, input int hi, input int load_pct);
        inst_t t;
        t.v   = ($urandom_range(0, 7) != 0);
        t.rs1 = RW'($urandom_range(lo, hi));
        t.rs2 = RW'($urandom_range(lo, hi));
        t.u1  = 1'($urandom_range(0, 1));
        t.u2  = 1'($urandom_range(0, 1));
        t.rd  = RW'($urandom_range(lo, hi));
        t.rw  = ($urandom_range(0, 3) != 0);
        t.mr  = ($urandom_range(0, 99) < load_pct);
        return t;
    endfunction

    initial begin : main
        inst_t nop;
        nop = '0;
        reset = 1'b1; branch_taken = 1'b0;
        id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 1'b0;
        id_uses_rs2 = 1'b0; id_rd = '0; id_regwrite = 1'b0; id_memread = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);

        // Reset values (reset still high on this edge, released after it).
        cycle(nop, 1'b0, 1'b1);
        check("rst_stall_count", stall_count, 8'd0);

        // ALU write r3, immediate reader then one-slot-later reader.
        cycle(mk(0, 0, 0, 0, 3, 1, 0), 1'b0, 1'b0);
        cycle(mk(3, 0, 1, 0, 4, 1, 0), 1'b0, 1'b0);
        cycle(mk(3, 1, 1, 0, 5, 1, 0), 1'b0, 1'b0);
        check("fwdA_mem_r3", {6'd0, forwardA}, 8'h02);
        cycle(nop, 1'b0, 1'b0);
        check("fwdA_wb_r3", {6'd0, forwardA}, 8'h01);

        // r2 produced in both MEM and WB: MEM wins.
        cycle(mk(0, 0, 0, 0, 2, 1, 0), 1'b0, 1'b0);
        cycle(mk(0, 0, 0, 0, 2, 1, 0), 1'b0, 1'b0);
        cycle(mk(0, 2, 0, 1, 6, 1, 0), 1'b0, 1'b0);
        cycle(nop, 1'b0, 1'b0);
        check("fwdB_mem_prio", {6'd0, forwardB}, 8'h02);

        // Load r5 then dependent reader: one stall, bubble, then WB forward.
        cycle(mk(0, 0, 0, 0, 5, 1, 1), 1'b0, 1'b0);
        cycle(mk(5, 0, 1, 0, 6, 1, 0), 1'b0, 1'b0);
        check("load_use_stall", {7'd0, stall}, 8'h01);
        cycle(mk(5, 0, 1, 0, 6, 1, 0), 1'b0, 1'b0);
        check("stall_one_cycle", {7'd0, stall}, 8'h00);
        cycle(nop, 1'b0, 1'b0);
        check("fwdA_after_stall", {6'd0, forwardA}, 8'h01);
        check("stall_count_1", stall_count, 8'd1);

        // Branch with branch_taken held through the flush window.
        cycle(nop, 1'b1, 1'b0);
        check("flush_not_yet", {7'd0, flush}, 8'h00);
        cycle(nop, 1'b1, 1'b0);
        check("flush_c1", {7'd0, flush}, 8'h01);
        cycle(nop, 1'b1, 1'b0);
        check("flush_c2", {7'd0, flush}, 8'h01);
        cycle(nop, 1'b0, 1'b0);
        check("flush_done", {7'd0, flush}, 8'h00);
        check("flush_count_1", flush_count, 8'd1);

        // Reset during the first flush cycle.
        cycle(mk(0, 0, 0, 0, 1, 1, 0), 1'b1, 1'b0);
        cycle(mk(1, 1, 1, 1, 2, 1, 0), 1'b0, 1'b1);
        cycle(nop, 1'b0, 1'b0);
        check("rst_mid_flush", {7'd0, flush}, 8'h00);
        check("rst_mid_fwd", {4'd0, forwardA, forwardB}, 8'h00);
        check("rst_mid_counts", stall_count | flush_count, 8'd0);

        // Load to r0 followed by a reader of r0.
        cycle(mk(0, 0, 0, 0, 0, 1, 1), 1'b0, 1'b0);
        cycle(mk(0, 0, 1, 0, 1, 1, 0), 1'b0, 1'b0);
        check("r0_load_use", {7'd0, stall}, R0Z ? 8'h00 : 8'h01);
        cycle(nop, 1'b0, 1'b0);
        cycle(nop, 1'b0, 1'b0);

        // Random mixed traffic with occasional branches and resets.
        for (int i = 0; i < 1500; i++)
            cycle(rnd_inst(0, 7, 30), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 149) == 0));

        // Dense load-use traffic to drive stall_count into saturation.
        cycle(nop, 1'b0, 1'b1);
        for (int i = 0; i < 1400; i++) begin
            inst_t t;
            t = rnd_inst(1, 2, 100);
            t.v = 1'b1; t.u1 = 1'b1;
            cycle(t, ($urandom_range(0, 49) == 0), 1'b0);
        end
        check("stall_sat", stall_count, 8'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_unit.md
# hazard_unit

- Pipeline-control counterpart to the execute stage.
- Tracks the destination-register tags of in-flight instructions across the EX, MEM and WB slots.
- Drives the operand-forwarding selects the execute stage consumes, plus the load-use stall.
- Consumes the execute stage's registered branch-taken flag and returns a multi-cycle flush to the execute stage and the fetch/decode registers.

## Interface

Parameters:
- REG_ADDR_W, 3: register-address width.
- FLUSH_CYCLES, 2: cycles flush stays high per taken branch; legal range 1–7.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- id_valid  in  1  decode slot holds a real instruction.
- id_rs1, id_rs2  in  REG_ADDR_W  source registers of decode instruction.
- id_uses_rs1, id_uses_rs2  in  1  source actually read.
- id_rd  in  REG_ADDR_W  destination register.
- id_regwrite  in  1  instruction writes rd.
- id_memread  in  1  instruction is a load.
- branch_taken  in  1  registered branch flag from the execute stage.
- forwardA, forwardB  out  2  operand select for EX: 00 register file, 01 WB data, 10 MEM ALU result; 11 never driven.
- stall  out  1  hold PC and IF/ID; insert bubble into EX.
- flush  out  1  squash EX result and IF/ID contents.
- stall_count, flush_count  out  8  saturating event counters.

## Operation

Tag pipeline: three slots EX, MEM and WB. Each slot holds {valid, rs1, rs2, uses_rs1, uses_rs2, rd, regwrite, memread}.
- Every edge: WB <= MEM, then MEM <= EX.
- EX <= decode fields when id_valid && !stall && !flush.
- Otherwise EX <= bubble (valid=0, regwrite=0, memread=0).

Forwarding (combinational from slot registers, forwardA shown; forwardB identical using rs2):
- 10 if MEM.valid && MEM.regwrite && MEM.rd==EX.rs1 && EX.uses_rs1.
- else 01 if the same test passes on the WB slot.
- else 00.
- MEM has priority over WB when both match.

Load-use stall (combinational):
- stall=1 when all of: FSM in RUN, id_valid, EX.valid, EX.memread, and (id_uses_rs1 && id_rs1==EX.rd or id_uses_rs2 && id_rs2==EX.rd).
- A stall lasts exactly one cycle; the bubble clears the match on the next cycle.

Branch FSM, states RUN and FLUSH:
- RUN -> FLUSH when branch_taken=1 at an edge; counter loads FLUSH_CYCLES-1.
- In FLUSH: flush=1; counter decrements each edge; FLUSH -> RUN on the edge where the counter is 0.
- branch_taken is ignored while in FLUSH, since it comes from a squashed instruction.
- flush is a registered output: high only in FLUSH, 0 in RUN.

Counters:
- stall_count increments on each edge where stall=1.
- flush_count increments on each RUN->FLUSH transition.
- Both saturate at 255.

## Timing

- Reset values:
  - FSM RUN, flush counter 0, all slots bubble.
  - forwardA=forwardB=00, stall=0, flush=0, counts 0.
- Forward selects: zero latency relative to the instruction occupying EX, valid the whole cycle.
- Flush: asserted the cycle after branch_taken is sampled high, for exactly FLUSH_CYCLES consecutive cycles.
- Simultaneous load-use match and branch_taken in RUN:
  - stall=1 that cycle.
  - Next cycle FSM is in FLUSH, so stall is forced 0 and flush=1.
- Stall during FLUSH is never asserted; the EX slot loads bubbles.
- Reset mid-FLUSH: next cycle is in RUN with flush=0 and all slots invalid, so no stale forwarding.
- Back-to-back branches: a new branch is accepted only when branch_taken is sampled in RUN. The first RUN cycle after a flush may re-enter FLUSH immediately.

## Configuration

HAZARD_R0_ZERO_EN:
- Defined: register 0 is hardwired zero. A slot with rd==0 never produces a forward or a stall (regwrite treated as 0 for matching); counters are unaffected by such matches.
- Undefined: r0 is treated like any other register.

## Test plan

- Reset, then ALU write r3 followed immediately by read of r3 in rs1 -> forwardA=10 for one cycle. Next dependent instruction one slot later -> forwardA=01.
- r2 written by both MEM and WB slots, EX reads r2 in rs2 -> forwardB=10 (MEM priority).
- Load to r5, next instruction reads r5 -> stall=1 for exactly one cycle, EX bubble, then forwardA=01 after the stall; stall_count=1.
- branch_taken pulse with FLUSH_CYCLES=2 -> flush high cycles N+1 and N+2; branch_taken held high during FLUSH is ignored; flush_count=1.
- Reset asserted in first FLUSH cycle -> next cycle flush=0, forwardA=forwardB=00, counts 0.
- With HAZARD_R0_ZERO_EN defined, load to r0 then read r0 -> stall=0, forwardA=00. Without it -> stall=1.
